// File: rtl/inv_key_sched_pkg.sv
// Shared crypto constants for the inverse key schedule: sizes, the
// schedule's round constant and the controller state encoding.
package inv_key_sched_pkg;

    localparam int KEY_SIZE   = 64;
    localparam int BLOCK_SIZE = 64;
    localparam int MAX_ROUNDS = 32;
    localparam int CNT_W      = 5;

    // Additive round constant mixed into every expansion step so that an
    // all-zero master key still produces a non-trivial chain.
    localparam logic [KEY_SIZE-1:0] KSA_CONST = 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } state_t;

endpackage

// File: rtl/inv_key_sched_ksa.sv
// One combinational key-schedule step: rotate left by 13, fold in a
// right shift by 7, and add the round index to the round constant.
module inv_key_sched_ksa
    import inv_key_sched_pkg::*;
(
    input  logic [CNT_W-1:0]    round,
    input  logic [KEY_SIZE-1:0] key,
    output logic [KEY_SIZE-1:0] new_key
);

    // Pure mixing function; no state.
    always_comb begin
        new_key = {key[KEY_SIZE-14:0], key[KEY_SIZE-1:KEY_SIZE-13]}
                ^ (key >> 7)
                ^ (KSA_CONST + {{(KEY_SIZE-CNT_W){1'b0}}, round});
    end

endmodule

// File: rtl/inv_key_sched.sv
// Inverse key schedule: expands a master key into NUM_ROUNDS round keys
// (one per cycle), then serves them last-to-first over a valid/ready port.
//
// Handshake: a round key transfers on a rising edge where rk_valid and
// rk_ready are both high. rk_valid never drops and rk/rk_round never
// change while a key is waiting; rk_ready is ignored while rk_valid is low.
module inv_key_sched
    import inv_key_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] key,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [KEY_SIZE-1:0] rk,
    output logic [CNT_W-1:0]    rk_round,
    output logic                done,
    output state_t              dbg_state
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] LAST_EXP = CNT_W'(NUM_ROUNDS - 2);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      idx;
    logic                  done_q;
    logic [KEY_SIZE-1:0]   key_buf [MAX_ROUNDS];
    logic [KEY_SIZE-1:0]   ksa_out;
    logic [CNT_W-1:0]      cnt_inc;

    assign cnt_inc = cnt + 5'd1;

    inv_key_sched_ksa u_ksa (
        .round   (cnt),
        .key     (key_buf[cnt]),
        .new_key (ksa_out)
    );

    // Next-state logic: expansion ends on the edge writing the last key;
    // serving ends on the handshake of round 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (cnt == LAST_EXP) state_nxt = SERVE;
            SERVE:   if (rk_ready && (idx == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Round counter, serve index and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) cnt <= '0;
                end
                EXPAND: begin
                    cnt <= cnt_inc;
                    if (cnt == LAST_EXP) idx <= LAST_IDX;
                end
                SERVE: begin
                    if (rk_ready) begin
                        if (idx == '0) done_q <= 1'b1;
                        else           idx    <= idx - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key storage; contents are only ever exposed while serving.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) key_buf[0]       <= key;
        if (state == EXPAND)          key_buf[cnt_inc] <= ksa_out;
    end

    // Outputs decode directly from state so nothing leaks outside SERVE.
    always_comb begin
        busy      = (state != IDLE);
        rk_valid  = (state == SERVE);
        rk        = rk_valid ? key_buf[idx] : '0;
        rk_round  = rk_valid ? idx : '0;
        done      = done_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_inv_key_sched.sv
// Randomized self-checking bench for inv_key_sched: a reference key chain
// is built from the schedule definition and drained through a queue as the
// DUT serves keys in reverse order.
module tb_inv_key_sched;
    import inv_key_sched_pkg::*;

    localparam int N = 32;
    localparam int W = KEY_SIZE;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   key = '0;
    logic           busy;
    logic           rk_valid;
    logic           rk_ready = 1'b0;
    logic [W-1:0]   rk;
    logic [4:0]     rk_round;
    logic           done;
    state_t         dbg_state;

    logic           start2 = 1'b0;
    logic [W-1:0]   key2 = '0;
    logic           busy2;
    logic           rk_valid2;
    logic           rk_ready2 = 1'b0;
    logic [W-1:0]   rk2;
    logic [4:0]     rk_round2;
    logic           done2;
    state_t         dbg_state2;

    int             n_checks = 0;
    int             n_fail = 0;
    logic [W-1:0]   exp_q[$];

    inv_key_sched #(.NUM_ROUNDS(N)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_round(rk_round),
        .done(done), .dbg_state(dbg_state)
    );

    inv_key_sched #(.NUM_ROUNDS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .key(key2), .busy(busy2),
        .rk_valid(rk_valid2), .rk_ready(rk_ready2), .rk(rk2), .rk_round(rk_round2),
        .done(done2), .dbg_state(dbg_state2)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference step: rotl13(k) xor (k >> 7) xor (constant + round).
    function automatic logic [W-1:0] ksa_model(input int r, input logic [W-1:0] k);
        logic [W-1:0] rot;
        rot = (k << 13) | (k >> (W - 13));
        return rot ^ (k >> 7) ^ (64'h9E3779B97F4A7C15 + W'(r));
    endfunction

    // Build the whole chain, then queue it last-to-first.
    task automatic build_expected(input logic [W-1:0] k, input int nr);
        logic [W-1:0] chain[$];
        chain.push_back(k);
        for (int r = 0; r < nr - 1; r++) chain.push_back(ksa_model(r, chain[r]));
        exp_q.delete();
        for (int i = nr - 1; i >= 0; i--) exp_q.push_back(chain[i]);
    endtask

    // Drive one job and score it. mode: 0 ready always high, 1 pattern 1,0,0,
    // 2 random. inj_cycle: EXPAND cycle at which a stray start is pulsed.
    // started: start was already driven by the previous call (done cycle).
    task automatic run_job(input logic [W-1:0] k, input int mode, input int inj_cycle,
                           input bit started, input bit chain_next, input logic [W-1:0] next_k);
        int           cyc;
        int           serve_cycles;
        int           exp_idx;
        bit           stalled;
        bit           rdy;
        logic [W-1:0] held_rk;
        logic [4:0]   held_round;

        build_expected(k, N);
        if (!started) begin
            key   = k;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", W'(busy), W'(1));
        check("done_low_in_job", W'(done), W'(0));

        while (!rk_valid && cyc < 200) begin
            if (cyc == inj_cycle) begin
                start = 1'b1;
                key   = ~k ^ 64'h5555_0000_aaaa_ffff;
            end else begin
                start = 1'b0;
            end
            rk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("first_valid_latency", W'(cyc), W'(N));

        exp_idx      = N - 1;
        stalled      = 1'b0;
        serve_cycles = 0;
        held_rk      = '0;
        held_round   = '0;
        while (exp_q.size() > 0 && serve_cycles < 2000) begin
            check("valid_in_serve", W'(rk_valid), W'(1));
            if (!rk_valid) break;
            check("rk", rk, exp_q[0]);
            check("rk_round", W'(rk_round), W'(exp_idx));
            check("done_low_serve", W'(done), W'(0));
            if (stalled) begin
                check("stall_rk_hold", rk, held_rk);
                check("stall_round_hold", W'(rk_round), W'(held_round));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((serve_cycles % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rk_ready   = rdy;
            held_rk    = rk;
            held_round = rk_round;
            stalled    = !rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                exp_idx--;
            end
            @(negedge clk);
            serve_cycles++;
        end
        check("all_keys_delivered", W'(exp_q.size()), W'(0));
        if (mode == 0) check("serve_cycles", W'(serve_cycles), W'(N));

        check("done_pulse", W'(done), W'(1));
        check("busy_after_done", W'(busy), W'(0));
        check("valid_after_done", W'(rk_valid), W'(0));
        check("rk_zero_idle", rk, W'(0));
        check("round_zero_idle", W'(rk_round), W'(0));
        rk_ready = 1'($urandom_range(0, 1));
        if (chain_next) begin
            key   = next_k;
            start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_single_pulse", W'(done), W'(0));
            check("idle_holds", W'(busy), W'(0));
        end
    endtask

    initial begin
        logic [W-1:0] k;
        logic [W-1:0] k_next;

        // Reset block.
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_valid", W'(rk_valid), W'(0));
        check("rst_rk", rk, W'(0));
        check("rst_round", W'(rk_round), W'(0));
        check("rst_done", W'(done), W'(0));
        reset = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_ignored", W'(rk_valid), W'(0));
        check("idle_busy", W'(busy), W'(0));

        // Zero key, streaming.
        run_job('0, 0, -1, 1'b0, 1'b0, '0);
        // All-ones key, streaming.
        run_job('1, 0, -1, 1'b0, 1'b0, '0);
        // Ready pattern 1,0,0 with stalls.
        k = {$urandom, $urandom};
        run_job(k, 1, -1, 1'b0, 1'b0, '0);
        // Stray start at EXPAND cycle 10.
        k = {$urandom, $urandom};
        run_job(k, 0, 10, 1'b0, 1'b0, '0);
        // Back-to-back: start accepted during the done cycle.
        k      = {$urandom, $urandom};
        k_next = {$urandom, $urandom};
        run_job(k, 2, -1, 1'b0, 1'b1, k_next);
        run_job(k_next, 0, -1, 1'b1, 1'b0, '0);

        // Abort mid-EXPAND with reset, then a fresh job.
        key   = {$urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_abort_busy", W'(busy), W'(1));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_valid", W'(rk_valid), W'(0));
        check("abort_rk", rk, W'(0));
        check("abort_round", W'(rk_round), W'(0));
        check("abort_done", W'(done), W'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", W'(done), W'(0));
            check("abort_stays_idle", W'(busy), W'(0));
        end
        run_job(64'h0123_4567_89ab_cdef, 2, -1, 1'b0, 1'b0, '0);

        // A few more random jobs.
        for (int j = 0; j < 3; j++) begin
            k = {$urandom, $urandom};
            run_job(k, int'($urandom_range(0, 2)), -1, 1'b0, 1'b0, '0);
        end

        // Two-round build.
        k         = {$urandom, $urandom};
        key2      = k;
        start2    = 1'b1;
        rk_ready2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        check("n2_cycle1_valid", W'(rk_valid2), W'(0));
        check("n2_cycle1_busy", W'(busy2), W'(1));
        @(negedge clk);
        check("n2_valid", W'(rk_valid2), W'(1));
        check("n2_round1", W'(rk_round2), W'(1));
        check("n2_rk1", rk2, ksa_model(0, k));
        rk_ready2 = 1'b1;
        @(negedge clk);
        check("n2_round0", W'(rk_round2), W'(0));
        check("n2_rk0", rk2, k);
        check("n2_valid0", W'(rk_valid2), W'(1));
        @(negedge clk);
        rk_ready2 = 1'b0;
        check("n2_done", W'(done2), W'(1));
        check("n2_idle", W'(busy2), W'(0));
        @(negedge clk);
        check("n2_done_pulse", W'(done2), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
